// File: rtl/serial_parity_receiver.sv
// UART-style frame deserialiser: start(0), d0..d3 LSB first, parity, stop(1).
// Presents data/parity with a one-cycle valid pulse; parity is not judged here.
module serial_parity_receiver #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              parity,
    output logic              valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    logic              rx_m;
    logic              rx_s;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              par_q;

    // Synchroniser, frame FSM and registered outputs in one block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            par_q     <= 1'b0;
            data      <= '0;
            parity    <= 1'b0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // False start: line went back high before mid-bit.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        if (idx == LAST_IDX) begin
                            state <= PARITY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        par_q <= rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            data   <= shreg;
                            parity <= par_q;
                            valid  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Directed bench for serial_parity_receiver: good frames, framing error,
// glitch rejection, back-to-back frames and asynchronous mid-frame reset.
module tb_serial_parity_receiver;

    localparam int CPB = 4;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [3:0] data;
    logic       parity;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_both  = 0;
    int         vcyc [0:31];
    logic [3:0] vdat [0:31];
    logic       vpar [0:31];

    serial_parity_receiver #(.CLKS_PER_BIT(CPB), .DATA_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .parity    (parity),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                if (n_valid < 32) begin
                    vcyc[n_valid] = cyc;
                    vdat[n_valid] = data;
                    vpar[n_valid] = parity;
                end
                n_valid = n_valid + 1;
            end
            if (frame_err) n_ferr = n_ferr + 1;
            if (valid && frame_err) n_both = n_both + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Caller must be aligned #1 after a rising edge.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stp);
        logic [6:0] bits;
        bits = {stp, p, d, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_v;
        int base_f;
        int lat;
        int gap;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: idle line after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {24'd0, data, parity, valid, frame_err, busy}, 32'd0);
        end
        @(posedge clk);
        #1;

        // 2: good frame 4'hB, parity 1
        base_v = n_valid;
        base_f = n_ferr;
        send_frame(4'hB, 1'b1, 1'b1);
        idle(4);
        @(negedge clk);
        check("good_valid_count", n_valid - base_v, 32'd1);
        check("good_ferr_count", n_ferr - base_f, 32'd0);
        lat = vcyc[base_v] - t0;
        check("good_latency_28pm1", (lat >= 27 && lat <= 29) ? 32'd1 : 32'd0, 32'd1);
        check("good_data", {28'd0, vdat[base_v]}, 32'hB);
        check("good_parity", {31'd0, vpar[base_v]}, 32'd1);
        check("good_data_held", {28'd0, data}, 32'hB);
        check("good_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // 3: stop bit low -> framing error, data unchanged
        base_v = n_valid;
        base_f = n_ferr;
        send_frame(4'h6, 1'b0, 1'b0);
        idle(10);
        @(negedge clk);
        check("ferr_count", n_ferr - base_f, 32'd1);
        check("ferr_no_valid", n_valid - base_v, 32'd0);
        check("ferr_data_kept", {28'd0, data}, 32'hB);
        check("ferr_parity_kept", {31'd0, parity}, 32'd1);
        @(posedge clk);
        #1;

        // 4: one-cycle glitch low
        base_v = n_valid;
        base_f = n_ferr;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_seen", {31'd0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", n_valid - base_v, 32'd0);
        check("glitch_no_ferr", n_ferr - base_f, 32'd0);
        @(posedge clk);
        #1;
        idle(4);

        // 5: back-to-back frames
        base_v = n_valid;
        send_frame(4'h3, 1'b0, 1'b1);
        send_frame(4'hC, 1'b1, 1'b1);
        idle(4);
        @(negedge clk);
        check("b2b_valid_count", n_valid - base_v, 32'd2);
        check("b2b_data0", {28'd0, vdat[base_v]}, 32'h3);
        check("b2b_par0", {31'd0, vpar[base_v]}, 32'd0);
        check("b2b_data1", {28'd0, vdat[base_v + 1]}, 32'hC);
        check("b2b_par1", {31'd0, vpar[base_v + 1]}, 32'd1);
        gap = vcyc[base_v + 1] - vcyc[base_v];
        check("b2b_gap", (gap >= 23 && gap <= 29) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;

        // 6: asynchronous reset in the middle of the data bits
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (CPB * 2) @(posedge clk);
        #2;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {24'd0, data, parity, valid, frame_err, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        base_v = n_valid;
        base_f = n_ferr;
        send_frame(4'h5, 1'b0, 1'b1);
        idle(4);
        @(negedge clk);
        check("post_reset_valid", n_valid - base_v, 32'd1);
        check("post_reset_ferr", n_ferr - base_f, 32'd0);
        check("post_reset_data", {28'd0, data}, 32'h5);
        check("post_reset_parity", {31'd0, parity}, 32'd0);

        check("never_both_pulses", n_both, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
